// File: rtl/adc_serial_multich_capture.sv
// Multi-channel serial ADC capture: one shared SCLK/CS_n, one frame per channel per
// conversion, results buffered in a first-word-fall-through sample FIFO with level irq.
module adc_serial_multich_capture #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DATA_BITS  = 12,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned QUIET_CLKS = 5,
  parameter int unsigned CLKDIV_W   = 8,
  parameter int unsigned CNT_W      = 12
) (
  input  logic                          SysClk,
  input  logic                          RST_n,
  input  logic                          cfg_enable,
  input  logic [CLKDIV_W-1:0]           cfg_clkdiv,
  input  logic [CNT_W-1:0]              cfg_conv_count,
  input  logic                          start,
  input  logic                          stop,
  input  logic [NUM_CH-1:0]             miso,
  output logic                          sclk,
  output logic                          cs_n,
  input  logic                          fifo_rd,
  output logic [NUM_CH*DATA_BITS-1:0]   fifo_rdata,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          irq_en,
  input  logic [$clog2(FIFO_DEPTH):0]   irq_threshold,
  input  logic                          irq_clr,
  output logic                          irq,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [CNT_W-1:0]              conv_index
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned SW = NUM_CH * DATA_BITS;
  localparam int unsigned BW = $clog2(FRAME_BITS + 1);
  localparam int unsigned QW = (QUIET_CLKS > 1) ? $clog2(QUIET_CLKS) : 1;
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CLKS - 1);
  localparam logic [LW-1:0] DEPTH      = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, SHIFT, QUIET} state_e;

  state_e               state_q, state_d;
  logic [CLKDIV_W-1:0]  div_q, div_d, clkdiv_q, clkdiv_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [QW-1:0]        qcnt_q, qcnt_d;
  logic [DATA_BITS-1:0] sr_q [NUM_CH];
  logic [DATA_BITS-1:0] sr_d [NUM_CH];
  logic [CNT_W-1:0]     count_q, count_d, conv_q, conv_d;
  logic                 stop_q, stop_d, sclk_q, sclk_d, done_q, done_d, ovf_q, ovf_d;
  logic [SW-1:0]        mem_q [FIFO_DEPTH];
  logic [SW-1:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 push_req, done_set, shift_en, pop, push_ok, full;
  logic [SW-1:0]        push_data;

  always_ff @(posedge SysClk or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      clkdiv_q <= '0;
      bit_q    <= '0;
      qcnt_q   <= '0;
      sr_q     <= '{default: '0};
      count_q  <= '0;
      conv_q   <= '0;
      stop_q   <= 1'b0;
      sclk_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mem_q    <= '{default: '0};
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      clkdiv_q <= clkdiv_d;
      bit_q    <= bit_d;
      qcnt_q   <= qcnt_d;
      sr_q     <= sr_d;
      count_q  <= count_d;
      conv_q   <= conv_d;
      stop_q   <= stop_d;
      sclk_q   <= sclk_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      level_q  <= level_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    clkdiv_d = clkdiv_q;
    bit_d    = bit_q;
    qcnt_d   = qcnt_q;
    sr_d     = sr_q;
    count_d  = count_q;
    conv_d   = conv_q;
    sclk_d   = sclk_q;
    stop_d   = stop_q | (stop && (state_q != IDLE));
    push_req = 1'b0;
    done_set = 1'b0;
    shift_en = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && cfg_enable) begin
          state_d  = START;
          clkdiv_d = cfg_clkdiv;
          count_d  = cfg_conv_count;
          conv_d   = '0;
          sr_d     = '{default: '0};
          div_d    = '0;
          bit_d    = '0;
        end
      end
      START: begin
        if (div_q == clkdiv_q) begin
          div_d    = '0;
          sclk_d   = 1'b1;
          shift_en = 1'b1;
          bit_d    = BW'(1);
          state_d  = SHIFT;
        end else begin
          div_d = div_q + CLKDIV_W'(1);
        end
      end
      SHIFT: begin
        if (div_q == clkdiv_q) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d  = QUIET;
              qcnt_d   = '0;
              push_req = 1'b1;
              conv_d   = conv_q + CNT_W'(1);
            end
          end else begin
            sclk_d   = 1'b1;
            shift_en = 1'b1;
            bit_d    = bit_q + BW'(1);
          end
        end else begin
          div_d = div_q + CLKDIV_W'(1);
        end
      end
      QUIET: begin
        if (qcnt_q == QUIET_LAST) begin
          if (stop_q || stop) begin
            state_d = IDLE;
          end else if ((count_q != '0) && (conv_q == count_q)) begin
            state_d  = IDLE;
            done_set = 1'b1;
          end else begin
            state_d = START;
            div_d   = '0;
          end
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides whatever the sequencer decided this cycle, including a pending push.
    if (!cfg_enable && (state_q != IDLE)) begin
      state_d  = IDLE;
      sclk_d   = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      qcnt_d   = '0;
      conv_d   = conv_q;
      push_req = 1'b0;
      done_set = 1'b0;
      shift_en = 1'b0;
    end
    if (state_d == IDLE) stop_d = 1'b0;

    if (shift_en) begin
      for (int unsigned k = 0; k < NUM_CH; k++) sr_d[k] = DATA_BITS'({sr_q[k], miso[k]});
    end
    for (int unsigned k = 0; k < NUM_CH; k++) push_data[k*DATA_BITS +: DATA_BITS] = sr_q[k];

    // A pop in the push cycle frees the slot, so a full FIFO can still accept.
    full    = (level_q == DEPTH);
    pop     = fifo_rd && (level_q != '0);
    push_ok = push_req && (!full || pop);
    mem_d   = mem_q;
    if (push_ok) mem_d[wr_q] = push_data;
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    level_d = level_q;
    if (push_ok && !pop) level_d = level_q + LW'(1);
    if (!push_ok && pop) level_d = level_q - LW'(1);

    done_d = done_q;
    if (irq_clr) done_d = 1'b0;
    if (done_set) done_d = 1'b1;
    ovf_d = ovf_q;
    if (irq_clr) ovf_d = 1'b0;
    if (push_req && !push_ok) ovf_d = 1'b1;
  end

  always_comb begin
    cs_n       = !((state_q == START) || (state_q == SHIFT));
    sclk       = sclk_q;
    busy       = (state_q != IDLE);
    fifo_empty = (level_q == '0);
    fifo_level = level_q;
    fifo_rdata = fifo_empty ? '0 : mem_q[rd_q];
    done       = done_q;
    overflow   = ovf_q;
    conv_index = conv_q;
    irq        = irq_en && (((irq_threshold != '0) && (level_q >= irq_threshold)) || done_q || ovf_q);
  end

endmodule
